// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: issue control, InstructionMemory port and the decode handshake.
interface fetch_sequencer_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;

  modport slave (
    input  fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, busy
  );

  modport master (
    output fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, tracks the one-cycle memory latency
// and buffers returned instructions in a 2-entry skid FIFO toward decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_instr_q [DEPTH];
  logic [31:0] fifo_instr_d [DEPTH];
  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_pc_d    [DEPTH];

  logic        pop_s;
  logic        push_s;
  logic        credit_ok_s;
  logic        issue_s;
  logic        wr_idx_s;
  logic [31:0] issue_pc_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC & PC_ALIGN_MASK;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]    <= 32'h0000_0000;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= fifo_instr_d[i];
        fifo_pc_q[i]    <= fifo_pc_d[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.fetch_en) state_d = FETCH; else state_d = IDLE;
      FETCH:   if (!bus.fetch_en) state_d = IDLE; else state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Issue, credit and FIFO update.
  always_comb begin
    pop_s  = (count_q != 2'd0) && bus.out_ready;
    push_s = inflight_q && !bus.redirect_valid;
    // Entries held plus the one in flight, minus what leaves now, must leave a free slot.
    credit_ok_s = ({1'b0, count_q} + {2'b00, inflight_q}) <= ({2'b00, pop_s} + 3'd1);
    issue_pc_s  = bus.redirect_valid ? (bus.redirect_pc & PC_ALIGN_MASK) : fetch_pc_q;
    // A redirect empties the FIFO and drops the inflight word, so it may always issue.
    issue_s     = (state_q == FETCH) && bus.fetch_en && (bus.redirect_valid || credit_ok_s);
    wr_idx_s    = rd_ptr_q ^ count_q[0];

    fetch_pc_d    = issue_s ? (issue_pc_s + 32'd4) : issue_pc_s;
    inflight_d    = issue_s;
    inflight_pc_d = issue_s ? issue_pc_s : inflight_pc_q;

    if (bus.redirect_valid) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
    end else begin
      count_d  = count_q + {1'b0, push_s} - {1'b0, pop_s};
      rd_ptr_d = rd_ptr_q ^ pop_s;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (int'(wr_idx_s) == i)) begin
        fifo_instr_d[i] = bus.imem_rdata;
        fifo_pc_d[i]    = inflight_pc_q;
      end else begin
        fifo_instr_d[i] = fifo_instr_q[i];
        fifo_pc_d[i]    = fifo_pc_q[i];
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.imem_addr = issue_pc_s >> 2;
    bus.out_valid = (count_q != 2'd0);
    bus.out_instr = fifo_instr_q[rd_ptr_q];
    bus.out_pc    = fifo_pc_q[rd_ptr_q];
    bus.busy      = (state_q == FETCH) || inflight_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, backpressure, redirect, fetch_en gating,
// PC wrap and asynchronous reset, against a synchronous-read memory model.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if bus0();
  fetch_sequencer_if bus1();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Memory model: word index w returns A000_0000 + w one cycle after the address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus0.imem_rdata <= 32'h0000_0000;
      bus1.imem_rdata <= 32'h0000_0000;
    end else begin
      bus0.imem_rdata <= 32'hA000_0000 + bus0.imem_addr;
      bus1.imem_rdata <= 32'hA000_0000 + bus1.imem_addr;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus0.fetch_en = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = 32'h0; bus0.out_ready = 1'b0;
    bus1.fetch_en = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'h0; bus1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Start streaming on dut0 and return at the negedge of the first valid cycle.
  task automatic start_until_valid(output bit ok);
    ok = 1'b0;
    bus0.fetch_en  = 1'b1;
    bus0.out_ready = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus0.out_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.out_instr !== 32'h0 || bus0.out_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b busy=%b instr=%h pc=%h, required 0 0 0 0",
               bus0.out_valid, bus0.busy, bus0.out_instr, bus0.out_pc);
    end
    checks++;
    if (bus0.imem_addr !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_addr0: got %h required 00000000", bus0.imem_addr);
    end
    checks++;
    if (bus1.imem_addr !== 32'h3FFF_FFFE) begin
      failures++;
      $display("FAIL reset_addr1: got %h required 3ffffffe", bus1.imem_addr);
    end
  endtask

  task automatic test_stream();
    int first_busy;
    int first_valid;
    do_reset();
    bus0.fetch_en  = 1'b1;
    bus0.out_ready = 1'b1;
    first_busy  = -1;
    first_valid = -1;
    for (int c = 0; c < 20 && first_valid < 0; c++) begin
      @(negedge clk);
      if (bus0.busy && first_busy < 0) first_busy = c;
      if (bus0.out_valid) first_valid = c;
    end
    checks++;
    if (first_valid < 0 || first_busy < 0 || (first_valid - first_busy) != 2) begin
      failures++;
      $display("FAIL stream_latency: first_busy=%0d first_valid=%0d, required distance 2", first_busy, first_valid);
    end
    checks++;
    if (bus0.out_pc !== 32'h0 || bus0.out_instr !== 32'hA000_0000) begin
      failures++;
      $display("FAIL stream_first: pc=%h instr=%h required 00000000 a0000000", bus0.out_pc, bus0.out_instr);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'(4 * k) || bus0.out_instr !== (32'hA000_0000 + 32'(k))) begin
        failures++;
        $display("FAIL stream_seq%0d: valid=%b pc=%h instr=%h required 1 %h %h", k,
                 bus0.out_valid, bus0.out_pc, bus0.out_instr, 32'(4 * k), 32'hA000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    logic [31:0] got_pc [3];
    logic [31:0] got_in [3];
    do_reset();
    start_until_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_start: no out_valid within budget, required one"); end
    bus0.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'h0) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b pc=%h required 1 00000000", c, bus0.out_valid, bus0.out_pc);
      end
    end
    checks++;
    if (bus0.imem_addr !== 32'h2) begin
      failures++;
      $display("FAIL bp_no_issue: imem_addr=%h required 00000002", bus0.imem_addr);
    end
    bus0.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus0.out_valid && n < 3) begin got_pc[n] = bus0.out_pc; got_in[n] = bus0.out_instr; n++; end
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL bp_count: got %0d pops required 3", n); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_pc[k] !== 32'(4 * k) || got_in[k] !== (32'hA000_0000 + 32'(k))) begin
          failures++;
          $display("FAIL bp_order%0d: pc=%h instr=%h required %h %h", k, got_pc[k], got_in[k],
                   32'(4 * k), 32'hA000_0000 + 32'(k));
        end
      end
    end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset();
    start_until_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rd_start: no out_valid within budget, required one"); end
    repeat (2) @(negedge clk);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h0000_0103;
    #1;
    checks++;
    if (bus0.imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL rd_addr: imem_addr=%h required 00000040", bus0.imem_addr);
    end
    @(posedge clk);
    #1 bus0.redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL rd_flush: valid=%b required 0", bus0.out_valid); end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'h100 || bus0.out_instr !== 32'hA000_0040) begin
      failures++;
      $display("FAIL rd_first: valid=%b pc=%h instr=%h required 1 00000100 a0000040",
               bus0.out_valid, bus0.out_pc, bus0.out_instr);
    end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'h104 || bus0.out_instr !== 32'hA000_0041) begin
      failures++;
      $display("FAIL rd_second: valid=%b pc=%h instr=%h required 1 00000104 a0000041",
               bus0.out_valid, bus0.out_pc, bus0.out_instr);
    end
    // Redirect again while stalled with a full FIFO.
    bus0.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h0000_0200;
    @(posedge clk);
    #1 bus0.redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL rd_full_flush: valid=%b required 0", bus0.out_valid); end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'h200 || bus0.out_instr !== 32'hA000_0080) begin
      failures++;
      $display("FAIL rd_full_first: valid=%b pc=%h instr=%h required 1 00000200 a0000080",
               bus0.out_valid, bus0.out_pc, bus0.out_instr);
    end
  endtask

  task automatic test_fetch_en();
    bit ok;
    int n;
    logic [31:0] got_pc [4];
    do_reset();
    start_until_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fe_start: no out_valid within budget, required one"); end
    bus0.fetch_en = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus0.out_valid && n < 4) begin got_pc[n] = bus0.out_pc; n++; end
      @(negedge clk);
    end
    checks++;
    if (n != 2 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin
      failures++;
      $display("FAIL fe_drain: pops=%0d first=%h second=%h required 2 00000000 00000004", n, got_pc[0], got_pc[1]);
    end
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0) begin
      failures++;
      $display("FAIL fe_idle: valid=%b busy=%b required 0 0", bus0.out_valid, bus0.busy);
    end
    bus0.fetch_en = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (bus0.out_valid) ok = 1'b1;
    end
    checks++;
    if (!ok || bus0.out_pc !== 32'h8 || bus0.out_instr !== 32'hA000_0002) begin
      failures++;
      $display("FAIL fe_resume: valid=%b pc=%h instr=%h required 1 00000008 a0000002",
               ok, bus0.out_pc, bus0.out_instr);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [31:0] got_pc [3];
    logic [31:0] got_in [3];
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_in[0] = 32'hDFFF_FFFE;
    exp_pc[1] = 32'hFFFF_FFFC; exp_in[1] = 32'hDFFF_FFFF;
    exp_pc[2] = 32'h0000_0000; exp_in[2] = 32'hA000_0000;
    do_reset();
    bus1.fetch_en  = 1'b1;
    bus1.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (bus1.out_valid) begin got_pc[n] = bus1.out_pc; got_in[n] = bus1.out_instr; n++; end
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL wrap_count: got %0d pops required 3", n); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_pc[k] !== exp_pc[k] || got_in[k] !== exp_in[k]) begin
          failures++;
          $display("FAIL wrap%0d: pc=%h instr=%h required %h %h", k, got_pc[k], got_in[k], exp_pc[k], exp_in[k]);
        end
      end
    end
    bus1.fetch_en = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    start_until_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ar_start: no out_valid within budget, required one"); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.imem_addr !== 32'h0 || bus0.out_pc !== 32'h0) begin
      failures++;
      $display("FAIL ar_immediate: valid=%b busy=%b addr=%h pc=%h required 0 0 00000000 00000000",
               bus0.out_valid, bus0.busy, bus0.imem_addr, bus0.out_pc);
    end
    #1 rst = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus0.out_valid) ok = 1'b1;
    end
    checks++;
    if (!ok || bus0.out_pc !== 32'h0 || bus0.out_instr !== 32'hA000_0000) begin
      failures++;
      $display("FAIL ar_restart: valid=%b pc=%h instr=%h required 1 00000000 a0000000",
               ok, bus0.out_pc, bus0.out_instr);
    end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'h4 || bus0.out_instr !== 32'hA000_0001) begin
      failures++;
      $display("FAIL ar_second: valid=%b pc=%h instr=%h required 1 00000004 a0000001",
               bus0.out_valid, bus0.out_pc, bus0.out_instr);
    end
  endtask

  initial begin
    bus0.fetch_en = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = 32'h0; bus0.out_ready = 1'b0;
    bus1.fetch_en = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'h0; bus1.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fetch_en();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
